// File: rtl/nono_line_scheduler.sv
// rtl/nono_line_scheduler.sv - option FIFO to line solver sequencer (optional pass limit: NONO_PASS_LIMIT_EN)
module nono_line_scheduler #(
    parameter int SIZE       = 3,
    parameter int CNT_W      = 7,
    parameter int MAX_PASSES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [2*SIZE-1:0][CNT_W-1:0]    init_amnt,
    input  logic [SIZE-1:0]                 fifo_dout,
    input  logic                            fifo_empty,
    input  logic                            fifo_full,
    output logic                            fifo_rd,
    output logic                            fifo_wr,
    output logic [SIZE-1:0]                 fifo_din,
    output logic                            solver_started,
    output logic                            solver_valid,
    output logic [SIZE-1:0]                 solver_option,
    input  logic                            solver_put_back,
    input  logic                            solver_solved,
    output logic                            busy,
    output logic                            done,
    output logic                            stuck,
`ifdef NONO_PASS_LIMIT_EN
    output logic                            timeout,
`endif
    output logic [2*SIZE-1:0][CNT_W-1:0]    old_options_amnt
);

    localparam int LINES  = 2 * SIZE;
    localparam int LINE_W = $clog2(LINES);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_IDX, S_OPT, S_RESP, S_PUT, S_ADV, S_DONE, S_STUCK
    } state_t;

    state_t                        state, state_d, after_opt;
    logic [LINES-1:0][CNT_W-1:0]   count;
    logic [LINE_W-1:0]             line;
    logic                          progress;
    logic                          first_flag;
    logic [CNT_W-1:0]              opt_left;
    logic [SIZE-1:0]               opt_q;
    logic                          do_start, do_idx, do_pop, do_rej, do_adv;

`ifdef NONO_PASS_LIMIT_EN
    localparam int PASS_W = $clog2(MAX_PASSES + 1);
    logic [PASS_W-1:0]             pass_cnt;
`endif

    assign busy             = (state != S_IDLE) && (state != S_DONE) && (state != S_STUCK);
    assign done             = (state == S_DONE);
    assign stuck            = (state == S_STUCK);
    assign old_options_amnt = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        after_opt      = (opt_left != '0) ? S_OPT : S_ADV;
        fifo_rd        = 1'b0;
        fifo_wr        = 1'b0;
        fifo_din       = '0;
        solver_valid   = 1'b0;
        solver_option  = '0;
        solver_started = 1'b0;
        do_start       = 1'b0;
        do_idx         = 1'b0;
        do_pop         = 1'b0;
        do_rej         = 1'b0;
        do_adv         = 1'b0;
`ifdef NONO_PASS_LIMIT_EN
        timeout        = 1'b0;
`endif
        // A solved board freezes everything, including a pending put-back write.
        if (busy && solver_solved) begin
            state_d = S_DONE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_STUCK: begin
                    if (start) begin
                        do_start = 1'b1;
                        state_d  = S_SEL;
                    end
                end
                S_SEL: begin
                    if (count[line] == '0) do_adv = 1'b1;
                    else                   state_d = S_IDX;
                end
                S_IDX: begin
                    solver_valid   = 1'b1;
                    solver_option  = SIZE'(line);
                    solver_started = first_flag;
                    do_idx         = 1'b1;
                    state_d        = S_OPT;
                end
                S_OPT: begin
                    if (!fifo_empty) begin
                        fifo_rd       = 1'b1;
                        solver_valid  = 1'b1;
                        solver_option = fifo_dout;
                        do_pop        = 1'b1;
                        state_d       = S_RESP;
                    end
                end
                S_RESP: begin
                    if (solver_put_back) begin
                        if (fifo_full) begin
                            state_d = S_PUT;
                        end else begin
                            fifo_wr  = 1'b1;
                            fifo_din = opt_q;
                            state_d  = after_opt;
                        end
                    end else begin
                        do_rej  = 1'b1;
                        state_d = after_opt;
                    end
                end
                S_PUT: begin
                    if (!fifo_full) begin
                        fifo_wr  = 1'b1;
                        fifo_din = opt_q;
                        state_d  = after_opt;
                    end
                end
                S_ADV:   do_adv  = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
        // Skipped lines advance straight from SEL so an empty line costs one cycle.
        if (do_adv) begin
            if (line != LAST_LINE) begin
                state_d = S_SEL;
            end else if (!progress) begin
                state_d = S_STUCK;
`ifdef NONO_PASS_LIMIT_EN
            end else if (pass_cnt == PASS_W'(MAX_PASSES - 1)) begin
                state_d = S_STUCK;
                timeout = 1'b1;
`endif
            end else begin
                state_d = S_SEL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            line       <= '0;
            progress   <= 1'b0;
            first_flag <= 1'b0;
            opt_left   <= '0;
            opt_q      <= '0;
`ifdef NONO_PASS_LIMIT_EN
            pass_cnt   <= '0;
`endif
        end else begin
            if (do_start) begin
                count      <= init_amnt;
                line       <= '0;
                progress   <= 1'b0;
                first_flag <= 1'b1;
`ifdef NONO_PASS_LIMIT_EN
                pass_cnt   <= '0;
`endif
            end
            if (do_idx) begin
                first_flag <= 1'b0;
                opt_left   <= count[line];
            end
            if (do_pop) begin
                opt_q    <= fifo_dout;
                opt_left <= opt_left - 1'b1;
            end
            if (do_rej) begin
                if (count[line] != '0) count[line] <= count[line] - 1'b1;
                progress <= 1'b1;
            end
            if (do_adv) begin
                if (line != LAST_LINE) begin
                    line <= line + 1'b1;
                end else begin
                    line     <= '0;
                    progress <= 1'b0;
`ifdef NONO_PASS_LIMIT_EN
                    pass_cnt <= pass_cnt + 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_nono_line_scheduler.sv
// tb/tb_nono_line_scheduler.sv - scoreboard bench for nono_line_scheduler
module tb_nono_line_scheduler;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [5:0][6:0]  init_amnt;
    logic [2:0]       fifo_dout;
    logic             fifo_empty, fifo_full;
    logic             fifo_rd, fifo_wr;
    logic [2:0]       fifo_din;
    logic             solver_started, solver_valid;
    logic [2:0]       solver_option;
    logic             solver_put_back, solver_solved;
    logic             busy, done, stuck;
    logic [5:0][6:0]  old_options_amnt;
`ifdef NONO_PASS_LIMIT_EN
    logic             timeout;
`endif

    nono_line_scheduler #(.SIZE(3), .CNT_W(7), .MAX_PASSES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .init_amnt(init_amnt),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .solver_started(solver_started), .solver_valid(solver_valid),
        .solver_option(solver_option), .solver_put_back(solver_put_back),
        .solver_solved(solver_solved), .busy(busy), .done(done), .stuck(stuck),
`ifdef NONO_PASS_LIMIT_EN
        .timeout(timeout),
`endif
        .old_options_amnt(old_options_amnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_idx;
        logic [2:0] val;
        bit         pb;
        bit         st;
        bit         sv;
    } beat_t;

    beat_t      exp_q[$];
    logic [2:0] fq[$];
    int         total = 0;
    int         bad = 0;
    int         wr_cnt = 0;
    int         to_cnt = 0;
    bit         force_empty = 1'b0;
    bit         force_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_idx(input logic [2:0] l, input bit st);
        beat_t e;
        e.is_idx = 1'b1; e.val = l; e.pb = 1'b0; e.st = st; e.sv = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_opt(input logic [2:0] v, input bit pb, input bit sv);
        beat_t e;
        e.is_idx = 1'b0; e.val = v; e.pb = pb; e.st = 1'b0; e.sv = sv;
        exp_q.push_back(e);
    endtask

    function automatic logic [41:0] amnt6(input int a0, a1, a2, a3, a4, a5);
        logic [5:0][6:0] v;
        v[0] = 7'(a0); v[1] = 7'(a1); v[2] = 7'(a2);
        v[3] = 7'(a3); v[4] = 7'(a4); v[5] = 7'(a5);
        return v;
    endfunction

    function automatic logic [23:0] pack_fq();
        logic [23:0] v = '0;
        for (int i = 0; i < fq.size() && i < 8; i++) v[i*3 +: 3] = fq[i];
        return v;
    endfunction

    // Solver and FIFO models: sample DUT at negedge, respond just after the next posedge.
    initial begin
        beat_t      e;
        bit         arm = 1'b0, a_pb = 1'b0, a_sv = 1'b0;
        logic       s_rd, s_wr;
        logic [2:0] s_din;
        solver_put_back = 1'b0; solver_solved = 1'b0;
        fifo_dout = '0; fifo_empty = 1'b1; fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            s_rd = fifo_rd; s_wr = fifo_wr; s_din = fifo_din;
            if (fifo_wr) wr_cnt++;
            if (fifo_rd && fifo_wr) chk("rd_wr_exclusive", 1, 0);
`ifdef NONO_PASS_LIMIT_EN
            if (timeout) to_cnt++;
`endif
            if (solver_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {61'd0, solver_option}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_val", solver_option, e.val);
                    chk("beat_kind_rd", fifo_rd, !e.is_idx);
                    chk("beat_started", solver_started, e.st);
                    if (!e.is_idx) begin
                        arm = 1'b1; a_pb = e.pb; a_sv = e.sv;
                    end
                end
            end
            @(posedge clk);
            #1;
            solver_put_back = arm & a_pb;
            solver_solved   = arm & a_sv;
            arm = 1'b0;
            if (s_rd && fq.size() > 0) void'(fq.pop_front());
            if (s_wr) fq.push_back(s_din);
            fifo_empty = (fq.size() == 0) || force_empty;
            fifo_dout  = (fq.size() > 0) ? fq[0] : 3'd0;
            fifo_full  = force_full;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int bound);
        int k = 0;
        while (!(done || stuck) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ended"}, done || stuck, 1);
        @(negedge clk);
        chk({name, "_all_beats"}, exp_q.size(), 0);
    endtask

    task automatic set_init(input int a0, a1, a2, a3, a4, a5);
        init_amnt = amnt6(a0, a1, a2, a3, a4, a5);
    endtask

    initial begin
        int w0, k;
        rst = 1'b1; start = 1'b0; init_amnt = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_flags", {done, stuck}, 0);
        chk("reset_amnt", old_options_amnt, 0);
        chk("reset_strobes", {fifo_rd, fifo_wr, solver_valid, solver_started}, 0);
        rst = 1'b0;

        // Reset mid-stream
        set_init(0, 2, 0, 0, 0, 1);
        fq.push_back(3'b100); fq.push_back(3'b010); fq.push_back(3'b001);
        push_idx(1, 1); push_opt(3'b100, 0, 0); push_opt(3'b010, 1, 0);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {busy, done, stuck, fifo_rd, fifo_wr, solver_valid, solver_started}, 0);
        chk("rst_amnt", old_options_amnt, 0);
        chk("rst_data", {fifo_din, solver_option}, 0);
        @(negedge clk);
        chk("rst_hold", {busy, done, stuck}, 0);
        rst = 1'b0;
        exp_q.delete(); fq.delete();
        repeat (2) @(negedge clk);

        // 3x3 board 110/010/101
        set_init(2, 3, 1, 1, 2, 3);
        fq.push_back(3'b110); fq.push_back(3'b011);
        fq.push_back(3'b100); fq.push_back(3'b010); fq.push_back(3'b001);
        fq.push_back(3'b101); fq.push_back(3'b101);
        fq.push_back(3'b110); fq.push_back(3'b011);
        fq.push_back(3'b100); fq.push_back(3'b010); fq.push_back(3'b001);
        push_idx(0, 1); push_opt(3'b110, 1, 0); push_opt(3'b011, 0, 0);
        push_idx(1, 0); push_opt(3'b100, 0, 0); push_opt(3'b010, 1, 0); push_opt(3'b001, 0, 0);
        push_idx(2, 0); push_opt(3'b101, 1, 0);
        push_idx(3, 0); push_opt(3'b101, 1, 0);
        push_idx(4, 0); push_opt(3'b110, 1, 0); push_opt(3'b011, 0, 0);
        push_idx(5, 0); push_opt(3'b100, 0, 0); push_opt(3'b010, 0, 0); push_opt(3'b001, 1, 1);
        w0 = wr_cnt;
        pulse_start();
        wait_end("board", 200);
        chk("board_done", {done, stuck, busy}, 3'b100);
        chk("board_amnt", old_options_amnt, amnt6(1, 1, 1, 1, 1, 1));
        chk("board_writes", wr_cnt - w0, 5);
        chk("board_fifo_size", fq.size(), 5);
        chk("board_fifo_data", pack_fq(), {9'd0, 3'b110, 3'b101, 3'b101, 3'b010, 3'b110});

        // Solver never rejects: one pass then stuck, FIFO order preserved
        fq.delete();
        set_init(1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            fq.push_back(3'(i + 1));
            push_idx(3'(i), i == 0);
            push_opt(3'(i + 1), 1, 0);
        end
        pulse_start();
        wait_end("keep", 200);
        chk("keep_flags", {done, stuck, busy}, 3'b010);
        chk("keep_amnt", old_options_amnt, amnt6(1, 1, 1, 1, 1, 1));
        chk("keep_fifo_size", fq.size(), 6);
        chk("keep_fifo_data", pack_fq(), {6'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});

        // Zero-count lines are skipped without index beats
        fq.delete();
        set_init(0, 2, 0, 0, 0, 1);
        fq.push_back(3'b100); fq.push_back(3'b010); fq.push_back(3'b001);
        push_idx(1, 1); push_opt(3'b100, 0, 0); push_opt(3'b010, 1, 0);
        push_idx(5, 0); push_opt(3'b001, 0, 0);
        push_idx(1, 0); push_opt(3'b010, 1, 0);
        pulse_start();
        wait_end("skip", 200);
        chk("skip_flags", {done, stuck}, 2'b01);
        chk("skip_amnt", old_options_amnt, amnt6(0, 1, 0, 0, 0, 0));
        chk("skip_fifo", {fq.size() == 1, pack_fq()}, {1'b1, 24'd2});

        // All counts zero: stuck within 2*SIZE+1 cycles
        fq.delete();
        set_init(0, 0, 0, 0, 0, 0);
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!stuck && k < 20);
        chk("zero_latency_ok", k <= 7, 1);
        chk("zero_stuck", {stuck, done}, 2'b10);

        // Back-pressure: empty FIFO during OPT, then full FIFO during put-back
        set_init(1, 0, 0, 0, 0, 0);
        fq.push_back(3'b010);
        force_empty = 1'b1; force_full = 1'b1;
        push_idx(0, 1); push_opt(3'b010, 1, 0);
        w0 = wr_cnt;
        pulse_start();
        repeat (8) @(negedge clk);
        chk("empty_no_opt_beat", exp_q.size(), 1);
        chk("empty_holds_busy", busy, 1);
        force_empty = 1'b0;
        repeat (3) @(negedge clk);
        chk("empty_release_beat", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("full_no_write", wr_cnt - w0, 0);
        chk("full_holds_busy", busy, 1);
        force_full = 1'b0;
        wait_end("bp", 100);
        chk("bp_one_write", wr_cnt - w0, 1);
        chk("bp_fifo", {fq.size() == 1, pack_fq()}, {1'b1, 24'd2});
        chk("bp_stuck", stuck, 1);

`ifdef NONO_PASS_LIMIT_EN
        // Pass limit of 2 with one rejection per pass
        fq.delete();
        set_init(2, 0, 0, 0, 0, 0);
        fq.push_back(3'b100); fq.push_back(3'b010);
        push_idx(0, 1); push_opt(3'b100, 0, 0); push_opt(3'b010, 1, 0);
        push_idx(0, 0); push_opt(3'b010, 0, 0);
        w0 = to_cnt;
        pulse_start();
        wait_end("limit", 200);
        chk("limit_timeout_pulses", to_cnt - w0, 1);
        chk("limit_stuck", {stuck, done}, 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
